// File: rtl/heap_ops.sv
// Shared encodings for the BBQ heap pair: heap operation codes and scheduler FSM states.
package heap_ops;

    typedef enum logic [1:0] {
        HEAP_OP_NOP       = 2'd0,
        HEAP_OP_ENQUE     = 2'd1,
        HEAP_OP_DEQUE_MIN = 2'd2,
        HEAP_OP_DEQUE_MAX = 2'd3
    } heap_op_t;

    typedef enum logic [1:0] {
        SCHED_INIT  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_STALL = 2'd2
    } bbq_sched_state_t;

endpackage

// File: rtl/bbq_occ_counter.sv
// Occupancy counter for one heap instance: up/down by one per cycle, with full and empty flags.
module bbq_occ_counter
    import heap_ops::*;
#(
    parameter  int CAPACITY = 64,
    localparam int CW       = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == CW'(CAPACITY));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/bbq_pair_scheduler.sv
// Enqueue/dequeue sequencer steering a two-instance BBQ router from a registered issue stage.
// Optional accept/stall statistics are built when BBQ_SCHED_STATS_EN is defined.
module bbq_pair_scheduler
    import heap_ops::*;
#(
    parameter  int DWIDTH      = 32,
    parameter  int PRIOR_WIDTH = 6,
    parameter  int CAPACITY    = 64,
    localparam int CW          = $clog2(CAPACITY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   heap_rdy,
    input  logic                   enq_valid,
    input  logic [DWIDTH-1:0]      enq_data,
    input  logic [PRIOR_WIDTH-1:0] enq_prior,
    output logic                   enq_ready,
    input  logic                   deq_valid,
    input  heap_op_t               deq_op,
    output logic                   deq_ready,
    output logic                   rtr_issue,
    output logic                   rtr_ctrl,
    output heap_op_t               rtr_op,
    output logic                   rtr_enq_en,
    output logic [DWIDTH-1:0]      rtr_data,
    output logic [PRIOR_WIDTH-1:0] rtr_prior,
    output logic [CW-1:0]          cnt0,
    output logic [CW-1:0]          cnt1
`ifdef BBQ_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_enq,
    output logic [31:0]            stat_deq,
    output logic [31:0]            stat_stall
`endif
);

    bbq_sched_state_t r_state;
    bbq_sched_state_t w_state_nxt;

    logic [CW-1:0] w_cnt0, w_cnt1;
    logic          w_full0, w_full1, w_empty0, w_empty1;
    logic          w_accepting;
    logic          w_deq_acc, w_enq_acc;
    logic          w_deq_tgt1, w_enq_tgt1, w_enq_tgt_full;
    logic          w_any_acc, w_ctrl_nxt;

    logic                   r_issue_p1;
    logic                   r_ctrl_p1;
    heap_op_t               r_op_p1;
    logic                   r_enq_en_p1;
    logic [DWIDTH-1:0]      r_data_p1;
    logic [PRIOR_WIDTH-1:0] r_prior_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SCHED_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCHED_INIT:  if (heap_rdy)  w_state_nxt = SCHED_RUN;
            SCHED_RUN:   if (!heap_rdy) w_state_nxt = SCHED_STALL;
            SCHED_STALL: if (heap_rdy)  w_state_nxt = SCHED_RUN;
            default:                    w_state_nxt = SCHED_INIT;
        endcase
    end

    // The enqueue target depends on whether a dequeue is taken this cycle, so it is resolved second.
    always_comb begin
        w_accepting    = (r_state == SCHED_RUN) && heap_rdy;
        deq_ready      = w_accepting && !(w_empty0 && w_empty1);
        w_deq_acc      = deq_valid && deq_ready;
        w_deq_tgt1     = (w_cnt1 > w_cnt0);
        w_enq_tgt1     = w_deq_acc ? !w_deq_tgt1 : (w_cnt1 < w_cnt0);
        w_enq_tgt_full = w_enq_tgt1 ? w_full1 : w_full0;
        enq_ready      = w_accepting && !w_enq_tgt_full;
        w_enq_acc      = enq_valid && enq_ready;
        w_any_acc      = w_deq_acc || w_enq_acc;
        w_ctrl_nxt     = w_deq_acc ? !w_deq_tgt1 : !w_enq_tgt1;
    end

    bbq_occ_counter #(.CAPACITY(CAPACITY)) u_occ0 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_enq_acc && !w_enq_tgt1),
        .i_dec   (w_deq_acc && !w_deq_tgt1),
        .o_cnt   (w_cnt0),
        .o_full  (w_full0),
        .o_empty (w_empty0)
    );

    bbq_occ_counter #(.CAPACITY(CAPACITY)) u_occ1 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_enq_acc && w_enq_tgt1),
        .i_dec   (w_deq_acc && w_deq_tgt1),
        .o_cnt   (w_cnt1),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

    // Stage p1: registered issue toward the router, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_p1  <= 1'b0;
            r_ctrl_p1   <= 1'b0;
            r_op_p1     <= HEAP_OP_NOP;
            r_enq_en_p1 <= 1'b0;
            r_data_p1   <= '0;
            r_prior_p1  <= '0;
        end else begin
            r_issue_p1  <= w_any_acc;
            r_ctrl_p1   <= w_any_acc && w_ctrl_nxt;
            r_op_p1     <= w_deq_acc ? deq_op : HEAP_OP_NOP;
            r_enq_en_p1 <= w_enq_acc;
            r_data_p1   <= w_enq_acc ? enq_data : '0;
            r_prior_p1  <= w_enq_acc ? enq_prior : '0;
        end
    end

    assign rtr_issue  = r_issue_p1;
    assign rtr_ctrl   = r_ctrl_p1;
    assign rtr_op     = r_op_p1;
    assign rtr_enq_en = r_enq_en_p1;
    assign rtr_data   = r_data_p1;
    assign rtr_prior  = r_prior_p1;
    assign cnt0       = w_cnt0;
    assign cnt1       = w_cnt1;

`ifdef BBQ_SCHED_STATS_EN
    logic [31:0] r_stat_enq, r_stat_deq, r_stat_stall;
    logic        w_stall;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign w_stall = (enq_valid && !enq_ready) || (deq_valid && !deq_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_enq   <= '0;
            r_stat_deq   <= '0;
            r_stat_stall <= '0;
        end else begin
            r_stat_enq   <= sat_inc32(r_stat_enq, w_enq_acc);
            r_stat_deq   <= sat_inc32(r_stat_deq, w_deq_acc);
            r_stat_stall <= sat_inc32(r_stat_stall, w_stall);
        end
    end

    assign stat_enq   = r_stat_enq;
    assign stat_deq   = r_stat_deq;
    assign stat_stall = r_stat_stall;
`else
    // Statistics hardware is not built in this configuration.
`endif

endmodule

// File: tb/tb_bbq_pair_scheduler.sv
// Scoreboard bench for bbq_pair_scheduler: directed scenarios followed by randomized traffic.
module tb_bbq_pair_scheduler;
    import heap_ops::*;

    localparam int DW  = 32;
    localparam int PW  = 6;
    localparam int CAP = 4;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          heap_rdy;
    logic          enq_valid;
    logic [DW-1:0] enq_data;
    logic [PW-1:0] enq_prior;
    logic          enq_ready;
    logic          deq_valid;
    heap_op_t      deq_op;
    logic          deq_ready;
    logic          rtr_issue;
    logic          rtr_ctrl;
    heap_op_t      rtr_op;
    logic          rtr_enq_en;
    logic [DW-1:0] rtr_data;
    logic [PW-1:0] rtr_prior;
    logic [CW-1:0] cnt0, cnt1;
`ifdef BBQ_SCHED_STATS_EN
    logic [31:0]   stat_enq, stat_deq, stat_stall;
`endif

    always #5 clk = ~clk;

    bbq_pair_scheduler #(.DWIDTH(DW), .PRIOR_WIDTH(PW), .CAPACITY(CAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .heap_rdy   (heap_rdy),
        .enq_valid  (enq_valid),
        .enq_data   (enq_data),
        .enq_prior  (enq_prior),
        .enq_ready  (enq_ready),
        .deq_valid  (deq_valid),
        .deq_op     (deq_op),
        .deq_ready  (deq_ready),
        .rtr_issue  (rtr_issue),
        .rtr_ctrl   (rtr_ctrl),
        .rtr_op     (rtr_op),
        .rtr_enq_en (rtr_enq_en),
        .rtr_data   (rtr_data),
        .rtr_prior  (rtr_prior),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`ifdef BBQ_SCHED_STATS_EN
        ,
        .stat_enq   (stat_enq),
        .stat_deq   (stat_deq),
        .stat_stall (stat_stall)
`endif
    );

    typedef struct {
        bit            ctrl;
        heap_op_t      op;
        bit            en;
        logic [DW-1:0] data;
        logic [PW-1:0] prior;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state: occupancy per instance and whether the block is accepting.
    int   mc[2];
    bit   mrun;
`ifdef BBQ_SCHED_STATS_EN
    longint s_enq, s_deq, s_stall;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every issue must match the oldest expected record, one cycle after its accept.
    always @(negedge clk) begin
        exp_t e;
        if (rtr_issue) begin
            if (sbq.size() == 0) begin
                check("issue_unexpected", rtr_issue, 0);
            end else begin
                e = sbq.pop_front();
                check("issue_ctrl", rtr_ctrl, e.ctrl);
                check("issue_op", rtr_op, e.op);
                check("issue_enq_en", rtr_enq_en, e.en);
                check("issue_data", rtr_data, e.data);
                check("issue_prior", rtr_prior, e.prior);
            end
        end else if (sbq.size() != 0) begin
            check("issue_missing", rtr_issue, 1);
            sbq.delete(0);
        end else begin
            check("idle_op", rtr_op, HEAP_OP_NOP);
            check("idle_fields", {rtr_ctrl, rtr_enq_en, rtr_data, rtr_prior}, 0);
        end
    end

    task automatic cyc(input bit hr, input bit ev, input logic [DW-1:0] d, input logic [PW-1:0] p,
                       input bit dv, input heap_op_t op, output bit ea, output bit da);
        int   dt, et;
        bit   dok, eok;
        exp_t e;
        @(negedge clk);
        rst       = 1'b0;
        heap_rdy  = hr;
        enq_valid = ev;
        enq_data  = d;
        enq_prior = p;
        deq_valid = dv;
        deq_op    = op;
        #1;
        check("cnt0", cnt0, mc[0]);
        check("cnt1", cnt1, mc[1]);
`ifdef BBQ_SCHED_STATS_EN
        check("stat_enq", stat_enq, s_enq);
        check("stat_deq", stat_deq, s_deq);
        check("stat_stall", stat_stall, s_stall);
`endif
        dok = mrun && hr && (mc[0] + mc[1] > 0);
        da  = dv && dok;
        dt  = (mc[1] > mc[0]) ? 1 : 0;
        et  = da ? (1 - dt) : ((mc[1] < mc[0]) ? 1 : 0);
        eok = mrun && hr && (mc[et] < CAP);
        ea  = ev && eok;
        check("deq_ready", deq_ready, dok);
        check("enq_ready", enq_ready, eok);
        if (ea || da) begin
            e.ctrl  = da ? (dt == 0) : (et == 0);
            e.op    = da ? op : HEAP_OP_NOP;
            e.en    = ea;
            e.data  = ea ? d : '0;
            e.prior = ea ? p : '0;
            sbq.push_back(e);
        end
        if (da) mc[dt]--;
        if (ea) mc[et]++;
`ifdef BBQ_SCHED_STATS_EN
        if (ea) s_enq++;
        if (da) s_deq++;
        if ((ev && !eok) || (dv && !dok)) s_stall++;
`endif
        mrun = hr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        heap_rdy  = 1'b0;
        enq_valid = 1'b0;
        deq_valid = 1'b0;
        mc[0]     = 0;
        mc[1]     = 0;
        mrun      = 1'b0;
`ifdef BBQ_SCHED_STATS_EN
        s_enq   = 0;
        s_deq   = 0;
        s_stall = 0;
`endif
    endtask

    initial begin
        bit            ea, da, pe, pd, hr;
        logic [DW-1:0] pdat;
        logic [PW-1:0] ppr;
        heap_op_t      pop;

        rst = 1'b1; heap_rdy = 1'b0; enq_valid = 1'b0; enq_data = '0; enq_prior = '0;
        deq_valid = 1'b0; deq_op = HEAP_OP_DEQUE_MIN;
        mc[0] = 0; mc[1] = 0; mrun = 1'b0;
`ifdef BBQ_SCHED_STATS_EN
        s_enq = 0; s_deq = 0; s_stall = 0;
`endif

        // Memory init in progress: enqueue held pending, readies stay low.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 32'h0000_A005, 6'd5, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
            check("init_enq_ready", enq_ready, 0);
            check("init_deq_ready", deq_ready, 0);
        end
        cyc(1'b1, 1'b1, 32'h0000_A005, 6'd5, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        cyc(1'b1, 1'b1, 32'h0000_A005, 6'd5, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("run_enq_ready", enq_ready, 1);
        cyc(1'b1, 1'b1, 32'h0000_B009, 6'd9, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        cyc(1'b1, 1'b1, 32'h0000_C002, 6'd2, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("three_enq_cnt0", cnt0, 2);
        check("three_enq_cnt1", cnt1, 1);

        // Simultaneous enqueue and dequeue-min from (2,1).
        cyc(1'b1, 1'b1, 32'h3333_3333, 6'd7, 1'b1, HEAP_OP_DEQUE_MIN, ea, da);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("pair_cnt0", cnt0, 1);
        check("pair_cnt1", cnt1, 2);

        // Drain to empty, then dequeue against empty heaps.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, '0, '0, 1'b1, HEAP_OP_DEQUE_MAX, ea, da);
        cyc(1'b1, 1'b0, '0, '0, 1'b1, HEAP_OP_DEQUE_MIN, ea, da);
        check("empty_cnt0", cnt0, 0);
        check("empty_cnt1", cnt1, 0);
        check("empty_deq_ready", deq_ready, 0);
        cyc(1'b1, 1'b1, 32'h0000_0044, 6'd3, 1'b1, HEAP_OP_DEQUE_MIN, ea, da);
        check("empty_pair_deq_ready", deq_ready, 0);
        check("empty_pair_enq_ready", enq_ready, 1);
        cyc(1'b1, 1'b0, '0, '0, 1'b1, HEAP_OP_DEQUE_MIN, ea, da);

        // Fill both instances, then collide enqueue with dequeue.
        for (int i = 0; i < 2 * CAP; i++)
            cyc(1'b1, 1'b1, $urandom, 6'($urandom), 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("full_cnt0", cnt0, CAP);
        check("full_cnt1", cnt1, CAP);
        cyc(1'b1, 1'b1, 32'h0000_0055, 6'd1, 1'b1, HEAP_OP_DEQUE_MIN, ea, da);
        check("collide_enq_ready", enq_ready, 0);
        check("collide_deq_ready", deq_ready, 1);
        cyc(1'b1, 1'b1, 32'h0000_0055, 6'd1, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("retry_enq_ready", enq_ready, 1);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("refill_cnt0", cnt0, CAP);
        check("refill_cnt1", cnt1, CAP);

        // Reset the cycle after an accept.
        cyc(1'b1, 1'b0, '0, '0, 1'b1, HEAP_OP_DEQUE_MAX, ea, da);
        do_reset();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("rst_issue", rtr_issue, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
`ifdef BBQ_SCHED_STATS_EN
        check("rst_stats", {stat_enq, stat_deq, stat_stall} == '0, 1);
`endif

        // Randomized traffic with held requests, heap_rdy drops and occasional resets.
        pe = 1'b0; pd = 1'b0; pdat = '0; ppr = '0; pop = HEAP_OP_DEQUE_MIN;
        for (int i = 0; i < 3000; i++) begin
            if (!pe) begin
                pe   = ($urandom_range(0, 99) < 60);
                pdat = $urandom;
                ppr  = 6'($urandom);
            end
            if (!pd) begin
                pd  = ($urandom_range(0, 99) < 45);
                pop = $urandom_range(0, 1) ? HEAP_OP_DEQUE_MIN : HEAP_OP_DEQUE_MAX;
            end
            hr = ($urandom_range(0, 99) < 88);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(hr, pe, pdat, ppr, pd, pop, ea, da);
                if (ea) pe = 1'b0;
                if (da) pd = 1'b0;
            end
        end

        cyc(1'b1, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, HEAP_OP_DEQUE_MIN, ea, da);
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
